// File: rtl/glb_rd_streamer_if.sv
// Command, bank-read and output-stream signals of the GLB read streamer.
// The slave modport is the streamer side; master is the environment (bank + consumer + commander).
interface glb_rd_streamer_if #(
  parameter int DATA_BITWIDTH = 32,
  parameter int ADDR_W        = 10
);
  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic [ADDR_W-1:0]        i_cmd_addr;
  logic [ADDR_W:0]          i_cmd_len;
  logic                     o_re;
  logic [ADDR_W-1:0]        o_ra;
  logic [DATA_BITWIDTH-1:0] i_rd;
  logic                     o_data_valid;
  logic                     i_data_ready;
  logic [DATA_BITWIDTH-1:0] o_data;
  logic                     o_data_last;
  logic                     o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_rd, i_data_ready,
    output o_cmd_ready, o_re, o_ra, o_data_valid, o_data, o_data_last, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_rd, i_data_ready,
    input  o_cmd_ready, o_re, o_ra, o_data_valid, o_data, o_data_last, o_busy
  );
endinterface

// File: rtl/glb_rd_streamer.sv
// Streams a contiguous (wrapping) range of words out of one GLB bank into a
// valid/ready beat stream, issuing reads only when the output FIFO has room for them.
module glb_rd_streamer #(
  parameter int DATA_BITWIDTH = 32,
  parameter int BANK_DEPTH    = 1024,
  parameter int ADDR_W        = $clog2(BANK_DEPTH),
  parameter int FIFO_DEPTH    = 4,
  parameter int RD_LAT        = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  glb_rd_streamer_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                 state_r, state_nxt_s;
  logic [ADDR_W-1:0]      addr_r;
  logic [LEN_W-1:0]       rem_r;
  logic [RD_LAT-1:0]      vld_pipe_r, last_pipe_r;
  logic [DATA_BITWIDTH:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   cmd_fire_s, issue_s, last_issue_s, credit_ok_s;
  logic                   push_s, pop_s, last_pop_s;
  int                     inflight_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(BANK_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign cmd_fire_s   = bus.i_cmd_valid && bus.o_cmd_ready;
  assign issue_s      = bus.o_re;
  assign last_issue_s = (rem_r == LEN_W'(1));
  assign push_s       = vld_pipe_r[RD_LAT-1];
  assign pop_s        = bus.o_data_valid && bus.i_data_ready;
  assign last_pop_s   = pop_s && bus.o_data_last;

  // Credit: reads already in the bank pipeline count against FIFO space.
  always_comb begin
    inflight_s = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + {31'd0, vld_pipe_r[i]};
    end
    credit_ok_s = ((int'(cnt_r) + inflight_s) < FIFO_DEPTH);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_fire_s && (bus.i_cmd_len != '0)) state_nxt_s = S_ISSUE;
        else                                     state_nxt_s = S_IDLE;
      end
      S_ISSUE: begin
        if (issue_s && last_issue_s) state_nxt_s = S_DRAIN;
        else                         state_nxt_s = S_ISSUE;
      end
      S_DRAIN: begin
        if (last_pop_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_DRAIN;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.o_cmd_ready = 1'b0;
    bus.o_busy      = 1'b1;
    bus.o_re        = 1'b0;
    case (state_r)
      S_IDLE: begin
        bus.o_cmd_ready = 1'b1;
        bus.o_busy      = 1'b0;
      end
      S_ISSUE: bus.o_re = credit_ok_s;
      S_DRAIN: bus.o_re = 1'b0;
      default: bus.o_busy = 1'b1;
    endcase
  end

  assign bus.o_ra = bus.o_re ? addr_r : '0;

  // Command address/count: latched on accept, advanced per issued read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r <= '0;
      rem_r  <= '0;
    end else if (cmd_fire_s) begin
      addr_r <= bus.i_cmd_addr;
      rem_r  <= bus.i_cmd_len;
    end else if (issue_s) begin
      addr_r <= addr_inc(addr_r);
      rem_r  <= rem_r - LEN_W'(1);
    end
  end

  // In-flight tracker aligned with the bank read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_r  <= '0;
      last_pipe_r <= '0;
    end else begin
      vld_pipe_r[0]  <= issue_s;
      last_pipe_r[0] <= issue_s && last_issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {last_pipe_r[RD_LAT-1], bus.i_rd};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign bus.o_data_valid = (cnt_r != '0);
  assign bus.o_data       = bus.o_data_valid ? fifo_mem_r[rd_ptr_r][DATA_BITWIDTH-1:0] : '0;
  assign bus.o_data_last  = bus.o_data_valid ? fifo_mem_r[rd_ptr_r][DATA_BITWIDTH] : 1'b0;
endmodule

// File: doc/glb_rd_streamer.md
GLB_RD_STREAMER -- requirements
Module: glb_rd_streamer

Interface
REQ-001 SHALL have parameters: DATA_BITWIDTH, default 32, read-data width; BANK_DEPTH, default 1024, words per GLB bank; ADDR_W, default clogb2(BANK_DEPTH-1)=10, bank address width; FIFO_DEPTH, default 4, output buffer entries (min 3); RD_LAT, default 2, bank read latency in cycles.
REQ-002 SHALL use one clock and an asynchronous active-low reset; ports are listed below with the clock and reset first.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_cmd_valid  in  1  command request.
REQ-006 o_cmd_ready  out  1  command accepted when both valid and ready are high.
REQ-007 i_cmd_addr  in  ADDR_W  start word address.
REQ-008 i_cmd_len  in  ADDR_W+1  word count, 0..BANK_DEPTH.
REQ-009 o_re  out  1  bank read enable, drives one GLB bank i_re bit.
REQ-010 o_ra  out  ADDR_W  bank read address, drives the matching i_ra slice.
REQ-011 i_rd  in  DATA_BITWIDTH  bank read data (o_rd slice), valid RD_LAT cycles after an o_re cycle.
REQ-012 o_data_valid  out  1  output beat valid.
REQ-013 i_data_ready  in  1  consumer ready.
REQ-014 o_data  out  DATA_BITWIDTH  output beat.
REQ-015 o_data_last  out  1  marks the final beat of a command.
REQ-016 o_busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-018 o_cmd_ready SHALL be high only in IDLE.
REQ-019 On a command handshake with len>0, the block SHALL latch addr and len and enter ISSUE.
REQ-020 A command with len==0 SHALL be accepted and then ignored: no o_re, no beats, state stays IDLE.
REQ-021 In ISSUE, o_re SHALL be high in a cycle iff (fifo_count + inflight) < FIFO_DEPTH.
REQ-022 When o_re is high, o_ra SHALL equal the current address.
REQ-023 Each issued read SHALL increment the current address modulo BANK_DEPTH (1023 wraps to 0) and decrement the remaining count.
REQ-024 When the last read issues, the FSM SHALL go to DRAIN.
REQ-025 DRAIN SHALL return to IDLE on the cycle after the last-flagged beat handshakes on the output.
REQ-026 A RD_LAT-deep valid/last shift pipeline SHALL track in-flight reads.
REQ-027 i_rd SHALL be written into the FIFO exactly when the pipeline output is valid.
REQ-028 Cycle timing: o_re high in cycle c SHALL make the corresponding beat visible on o_data_valid no earlier than cycle c+3.
REQ-029 With i_data_ready held high, the block SHALL sustain 1 beat per cycle after the first beat.
REQ-030 The FIFO SHALL never overflow; the credit check guarantees this.
REQ-031 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-032 o_data and o_data_last SHALL hold stable while o_data_valid=1 and i_data_ready=0.
REQ-033 o_data_last SHALL be high only with the beat of the final word of a command.
REQ-034 Beat order SHALL equal address issue order.
REQ-035 i_rd SHALL be ignored whenever the pipeline output is not valid.

Reset
REQ-036 While i_rst_n=0: state=IDLE; o_cmd_ready=1 (IDLE output); o_re=0; o_ra=0; o_data_valid=0; o_data=0; o_data_last=0; o_busy=0.
REQ-037 Reset SHALL clear the FIFO, the in-flight pipeline, the address and the count.
REQ-038 Reset asserted mid-command SHALL abort that command; in-flight bank data arriving after reset release SHALL be discarded.
REQ-039 The first command accepted after reset SHALL behave as a command from a fresh IDLE.

Verification
REQ-040 addr=5, len=4, ready held 1 -> o_ra=5,6,7,8 on consecutive cycles; 4 beats with data=mem[5..8]; last flag on the 4th beat; o_busy drops afterward.
REQ-041 addr=1022, len=4 -> o_ra sequence 1022,1023,0,1; beats in the same order.
REQ-042 len=6, i_data_ready=0 for 10 cycles then 1 -> o_re stops after 4 issues; no beat lost or duplicated; all 6 beats delivered in order.
REQ-043 len=0 -> handshake completes; no o_re; no o_data_valid; o_busy stays 0.
REQ-044 i_rst_n pulsed low with 2 reads in flight -> all outputs at reset values; next command addr=0, len=2 yields exactly 2 beats, mem[0] and mem[1].
REQ-045 Random ready toggling, 200 random commands against a GLB bank model with RD_LAT=2 -> output stream matches the scoreboard; FIFO count never exceeds FIFO_DEPTH.
